// File: rtl/adder_issuer_pkg.sv
// rtl/adder_issuer_pkg.sv - shared types, defaults and wrapped-sum helper for adder_issuer
package adder_issuer_pkg;

  localparam int WIDTH_DEFAULT   = 4;
  localparam int LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Sum of two operands folded into w bits; the carry out is discarded.
  function automatic logic [31:0] wrap_sum(input logic [31:0] a, input logic [31:0] b,
                                           input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/adder_issuer_if.sv
// rtl/adder_issuer_if.sv - request/response channels plus adder unit operand/result wires
interface adder_issuer_if #(
  parameter int WIDTH = adder_issuer_pkg::WIDTH_DEFAULT
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] unit_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             mismatch;

  modport slave (
    input  req_valid, req_a, req_b, unit_result, rsp_ready,
    output req_ready, op_a, op_b, rsp_valid, rsp_data, mismatch
  );

  modport master (
    output req_valid, req_a, req_b, unit_result, rsp_ready,
    input  req_ready, op_a, op_b, rsp_valid, rsp_data, mismatch
  );

endinterface

// File: rtl/adder_issuer.sv
// rtl/adder_issuer.sv - issues operand pairs to the registered adder unit and returns its sum
// after a fixed, operand-independent wait; flags any result that disagrees with a local sum.
module adder_issuer
  import adder_issuer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  adder_issuer_if.slave  bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_valid;
  logic             r_mismatch;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic [WIDTH-1:0] w_expected;

  assign w_expected = WIDTH'(wrap_sum(32'(r_op_a), 32'(r_op_b), WIDTH));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      // The wait always runs the full count, so response timing never depends on operands.
      WAIT: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a <= bus.req_a;
        r_op_b <= bus.req_b;
        r_cnt  <= CNT_W'(LATENCY);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_data  <= bus.unit_result;
        r_rsp_valid <= 1'b1;
        if (bus.unit_result != w_expected) r_mismatch <= 1'b1;
      end else if (w_release) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mismatch  = r_mismatch;

endmodule

// File: tb/tb_adder_issuer.sv
// tb/tb_adder_issuer.sv - adder_issuer driven against a behavioural two-stage adder unit
module tb_adder_issuer;

  logic       clk;
  logic       rst;
  logic       force_en;
  logic [3:0] force_val;
  logic [3:0] u_s1;
  logic [3:0] u_s2;
  int         n_cmp;
  int         n_err;
  bit         mdl_mm;

  adder_issuer_if #(.WIDTH(4)) bus ();

  adder_issuer #(.WIDTH(4), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    u_s1 <= bus.op_a + bus.op_b;
    u_s2 <= u_s1;
  end
  assign bus.unit_result = force_en ? force_val : u_s2;

  function automatic logic [3:0] ref_sum(input logic [3:0] a, input logic [3:0] b);
    return 4'((int'(a) + int'(b)) % 16);
  endfunction

  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int hold,
                         input bit fault, input logic [3:0] fval, input bit extra_req);
    logic [3:0] exp;
    logic [3:0] exp2;
    int lat;
    bit got;
    exp = fault ? fval : ref_sum(a, b);
    @(negedge clk);
    force_en = fault; force_val = fval;
    bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_idle got=%b exp=1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_a = 4'($urandom); bus.req_b = 4'($urandom);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (bus.rsp_valid === 1'b1) got = 1;
      if (lat == 1) begin
        n_cmp++; if (bus.op_a !== a || bus.op_b !== b) begin n_err++; $display("FAIL op_issue got=%h/%h exp=%h/%h", bus.op_a, bus.op_b, a, b); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL req_ready_wait got=%b exp=0", bus.req_ready); end
      end
    end
    n_cmp++; if (lat != 4 || !got) begin n_err++; $display("FAIL latency got=%0d exp=4 seen=%0d", lat, got); end
    if (exp != ref_sum(a, b)) mdl_mm = 1'b1;
    n_cmp++; if (bus.rsp_data !== exp) begin n_err++; $display("FAIL rsp_data got=%h exp=%h", bus.rsp_data, exp); end
    n_cmp++; if (bus.mismatch !== mdl_mm) begin n_err++; $display("FAIL mismatch got=%b exp=%b", bus.mismatch, mdl_mm); end
    if (extra_req) begin bus.req_a = ~a; bus.req_b = b; bus.req_valid = 1'b1; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp) begin n_err++; $display("FAIL rsp_hold got=%b/%h exp=1/%h", bus.rsp_valid, bus.rsp_data, exp); end
      n_cmp++; if (bus.req_ready !== 1'b0 || bus.op_a !== a) begin n_err++; $display("FAIL no_bypass got=%b/%h exp=0/%h", bus.req_ready, bus.op_a, a); end
    end
    force_en = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_handshake got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    n_cmp++; if (bus.op_a !== a || bus.op_b !== b) begin n_err++; $display("FAIL op_held got=%h/%h exp=%h/%h", bus.op_a, bus.op_b, a, b); end
    if (extra_req) begin
      exp2 = ref_sum(~a, b);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n_cmp++; if (bus.op_a !== ~a) begin n_err++; $display("FAIL late_accept got=%h exp=%h", bus.op_a, ~a); end
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp2) begin n_err++; $display("FAIL second_rsp got=%b/%h exp=1/%h", bus.rsp_valid, bus.rsp_data, exp2); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.req_valid = 1'b1; bus.req_a = 4'hA; bus.req_b = 4'h5; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_hs got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
    n_cmp++; if (bus.op_a !== 4'h0 || bus.op_b !== 4'h0) begin n_err++; $display("FAIL reset_ops got=%h/%h exp=0/0", bus.op_a, bus.op_b); end
    n_cmp++; if (bus.rsp_data !== 4'h0 || bus.mismatch !== 1'b0) begin n_err++; $display("FAIL reset_data got=%h/%b exp=0/0", bus.rsp_data, bus.mismatch); end
    rst = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    mdl_mm = 1'b0;
  endtask

  task automatic test_basic();
    run_txn(4'd3, 4'd4, 0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_wrap();
    run_txn(4'd9, 4'd8, 1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_constant_time();
    run_txn(4'd0, 4'd0, 0, 1'b0, 4'd0, 1'b0);
    run_txn(4'd15, 4'd15, 0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(4'd5, 4'd6, 4, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_fault();
    run_txn(4'd1, 4'd2, 0, 1'b1, 4'd2, 1'b0);
    run_txn(4'd2, 4'd2, 0, 1'b0, 4'd0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; mdl_mm = 1'b0;
    n_cmp++; if (bus.mismatch !== 1'b0) begin n_err++; $display("FAIL mismatch_clear got=%b exp=0", bus.mismatch); end
  endtask

  task automatic test_reset_mid_op();
    bit pulse;
    @(negedge clk);
    bus.req_a = 4'd7; bus.req_b = 4'd6; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'h0) begin n_err++; $display("FAIL midop_hs got=%b/%b/%h exp=1/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_data); end
    n_cmp++; if (bus.op_a !== 4'h0 || bus.op_b !== 4'h0 || bus.mismatch !== 1'b0) begin n_err++; $display("FAIL midop_ops got=%h/%h/%b exp=0/0/0", bus.op_a, bus.op_b, bus.mismatch); end
    pulse = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) pulse = 1'b1; end
    n_cmp++; if (pulse) begin n_err++; $display("FAIL midop_pulse got=1 exp=0"); end
    run_txn(4'd2, 4'd9, 0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_txn(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; mdl_mm = 1'b0;
    rst = 1'b1; force_en = 1'b0; force_val = 4'd0;
    bus.req_valid = 1'b0; bus.req_a = 4'd0; bus.req_b = 4'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_constant_time();
    test_backpressure();
    test_fault();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
